// File: rtl/lsu_pkg.sv
// Shared types and funct3 encodings for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Unsigned variants only exist for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = ~is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering for stores, extract/extend for loads, and access legality.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        i_read,
  input  logic        i_write,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_store_data,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_wstrb,
  output logic        o_illegal,
  output logic [31:0] o_load_data
);

  logic        w_misalign;
  logic [31:0] w_shifted;

  // Store data replication and byte strobes
  always_comb begin
    o_wdata = 32'h0000_0000;
    o_wstrb = 4'b0000;
    case (i_funct3)
      F3_B: begin
        o_wdata = {4{i_store_data[7:0]}};
        o_wstrb = 4'b0001 << i_addr_lo;
      end
      F3_H: begin
        o_wdata = {2{i_store_data[15:0]}};
        o_wstrb = 4'b0011 << i_addr_lo;
      end
      F3_W: begin
        o_wdata = i_store_data;
        o_wstrb = 4'b1111;
      end
      default: begin
        o_wdata = 32'h0000_0000;
        o_wstrb = 4'b0000;
      end
    endcase
  end

  // Misalignment and illegal-encoding detect
  always_comb begin
    w_misalign = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: w_misalign = i_addr_lo[0];
      F3_W:        w_misalign = (i_addr_lo != 2'b00);
      default:     w_misalign = 1'b0;
    endcase
    o_illegal = (i_read & i_write) | ~f3_legal(i_funct3, i_write) | w_misalign;
  end

  // Load byte/half extraction and extension
  always_comb begin
    w_shifted   = i_rdata >> {i_ld_addr_lo, 3'b000};
    o_load_data = 32'h0000_0000;
    case (i_ld_funct3)
      F3_B:    o_load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      F3_H:    o_load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_W:    o_load_data = i_rdata;
      F3_BU:   o_load_data = {24'h00_0000, w_shifted[7:0]};
      F3_HU:   o_load_data = {16'h0000, w_shifted[15:0]};
      default: o_load_data = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one req/gnt/rvalid data-bus transaction per instruction, stalls until done.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemValid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUout,
  input  logic [31:0] RegOp2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        LsuStall,
  output logic        LsuDone,
  output logic        LsuFault,
  output logic [31:0] LoadData
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_e  r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]  r_addr_lo;
  logic [2:0]  r_funct3;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_done;
  logic        r_fault;
  logic [31:0] r_load_data;

  logic        w_start;
  logic        w_timeout;
  logic        w_illegal;
  logic [31:0] w_wdata;
  logic [3:0]  w_wstrb;
  logic [31:0] w_load_data;

  assign w_start   = MemValid & (MemRead | MemWrite);
  // >= because a load granted on the last REQ cycle enters WAIT one past CNT_LAST.
  assign w_timeout = (r_cnt >= CNT_LAST);

  lsu_align u_align (
    .i_read       (MemRead),
    .i_write      (MemWrite),
    .i_funct3     (funct3),
    .i_addr_lo    (ALUout[1:0]),
    .i_store_data (RegOp2),
    .i_ld_funct3  (r_funct3),
    .i_ld_addr_lo (r_addr_lo),
    .i_rdata      (mem_rdata),
    .o_wdata      (w_wdata),
    .o_wstrb      (w_wstrb),
    .o_illegal    (w_illegal),
    .o_load_data  (w_load_data)
  );

  // Transaction FSM with timeout counter and registered bus/pipeline outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr_lo   <= 2'b00;
      r_funct3    <= 3'b000;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 32'h0000_0000;
      r_wdata     <= 32'h0000_0000;
      r_wstrb     <= 4'b0000;
      r_done      <= 1'b0;
      r_fault     <= 1'b0;
      r_load_data <= 32'h0000_0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_addr    <= {ALUout[31:2], 2'b00};
            r_addr_lo <= ALUout[1:0];
            r_funct3  <= funct3;
            r_we      <= MemWrite;
            r_wdata   <= w_wdata;
            r_wstrb   <= w_wstrb;
            if (w_illegal) begin
              r_state     <= RESP;
              r_done      <= 1'b1;
              r_fault     <= 1'b1;
              r_load_data <= 32'h0000_0000;
            end else begin
              r_state <= REQ;
              r_req   <= 1'b1;
              r_cnt   <= '0;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            r_req <= 1'b0;
            r_cnt <= r_cnt + 1'b1;
            if (r_we) begin
              r_state <= RESP;
              r_done  <= 1'b1;
              r_fault <= 1'b0;
            end else begin
              r_state <= WAIT;
            end
          end else if (w_timeout) begin
            r_req       <= 1'b0;
            r_state     <= RESP;
            r_done      <= 1'b1;
            r_fault     <= 1'b1;
            r_load_data <= 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid) begin
            r_state     <= RESP;
            r_done      <= 1'b1;
            r_fault     <= 1'b0;
            r_load_data <= w_load_data;
          end else if (w_timeout) begin
            r_state     <= RESP;
            r_done      <= 1'b1;
            r_fault     <= 1'b1;
            r_load_data <= 32'h0000_0000;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
          r_done  <= 1'b0;
          r_fault <= 1'b0;
        end
      endcase
    end
  end

  assign LsuStall  = rst_n & (((r_state == IDLE) & w_start) | (r_state == REQ) | (r_state == WAIT));
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wstrb = r_wstrb;
  assign LsuDone   = r_done;
  assign LsuFault  = r_fault;
  assign LoadData  = r_load_data;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with hand-computed expectations.
module tb_load_store_unit;

  logic        clk, rst_n;
  logic        MemValid, MemRead, MemWrite;
  logic [2:0]  funct3;
  logic [31:0] ALUout, RegOp2;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        LsuStall, LsuDone, LsuFault;
  logic [31:0] LoadData;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .MemValid(MemValid), .MemRead(MemRead), .MemWrite(MemWrite),
    .funct3(funct3), .ALUout(ALUout), .RegOp2(RegOp2), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .LsuStall(LsuStall), .LsuDone(LsuDone),
    .LsuFault(LsuFault), .LoadData(LoadData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] data);
    MemValid = v; MemRead = rd; MemWrite = wr; funct3 = f3; ALUout = addr; RegOp2 = data;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    #3;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, LsuStall, LsuDone, LsuFault, LoadData} !== 104'h0) begin
      errors++;
      $display("FAIL reset_outputs: req=%b we=%b addr=%h wdata=%h wstrb=%b stall=%b done=%b fault=%b ld=%h, required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, LsuStall, LsuDone, LsuFault, LoadData);
    end
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_store_word();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    mem_gnt = 1'b1;
    #1;
    checks++;
    if (LsuStall !== 1'b1) begin errors++; $display("FAIL sw_stall_c0: got %b required 1", LsuStall); end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, LsuStall, LsuDone} !== {1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL sw_req: req=%b we=%b addr=%h wdata=%h wstrb=%b stall=%b done=%b, required 1 1 00000100 deadbeef 1111 1 0",
               mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, LsuStall, LsuDone);
    end
    next_cycle();
    mem_gnt = 1'b0;
    checks++;
    if ({LsuDone, LsuFault, LsuStall, mem_req} !== 4'b1000) begin
      errors++;
      $display("FAIL sw_done: done/fault/stall/req=%b required 1000", {LsuDone, LsuFault, LsuStall, mem_req});
    end
    next_cycle();
    checks++;
    if (LsuDone !== 1'b0) begin errors++; $display("FAIL sw_done_pulse: got %b required 0", LsuDone); end
  endtask

  task automatic test_loads();
    logic [2:0]  f3_t [3]  = '{3'b000, 3'b100, 3'b001};
    logic [31:0] adr_t [3] = '{32'h0000_0203, 32'h0000_0203, 32'h0000_0202};
    logic [31:0] exp_t [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, f3_t[i], adr_t[i], 32'h0);
      mem_gnt = 1'b1;
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      mem_rvalid = 1'b1; mem_rdata = 32'h1111_1111;
      checks++;
      if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 32'h0000_0200}) begin
        errors++;
        $display("FAIL load%0d_req: req=%b we=%b addr=%h required 1 0 00000200", i, mem_req, mem_we, mem_addr);
      end
      next_cycle();
      mem_gnt = 1'b0; mem_rdata = 32'h80FF_0000;
      checks++;
      if ({LsuDone, LsuStall} !== 2'b01) begin
        errors++; $display("FAIL load%0d_wait: done/stall=%b required 01", i, {LsuDone, LsuStall});
      end
      next_cycle();
      mem_rvalid = 1'b0;
      checks++;
      if ({LsuDone, LsuFault, LoadData} !== {1'b1, 1'b0, exp_t[i]}) begin
        errors++;
        $display("FAIL load%0d_data: done=%b fault=%b data=%h required 1 0 %h", i, LsuDone, LsuFault, LoadData, exp_t[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_store_half();
    drive(1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0006, 32'h1234_ABCD);
    mem_gnt = 1'b1;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_0004, 32'hABCD_ABCD, 4'b1100}) begin
      errors++;
      $display("FAIL sh_lanes: req=%b addr=%h wdata=%h wstrb=%b required 1 00000004 abcdabcd 1100",
               mem_req, mem_addr, mem_wdata, mem_wstrb);
    end
    next_cycle();
    mem_gnt = 1'b0;
    checks++;
    if ({LsuDone, LsuFault} !== 2'b10) begin errors++; $display("FAIL sh_done: done/fault=%b required 10", {LsuDone, LsuFault}); end
    next_cycle();
  endtask

  task automatic test_illegal();
    logic saw_req;
    logic        rd_t [3] = '{1'b1, 1'b0, 1'b1};
    logic        wr_t [3] = '{1'b0, 1'b1, 1'b1};
    logic [2:0]  f3_t [3] = '{3'b010, 3'b100, 3'b000};
    for (int i = 0; i < 3; i++) begin
      saw_req = 1'b0;
      mem_gnt = 1'b1;
      drive(1'b1, rd_t[i], wr_t[i], f3_t[i], 32'h0000_0006, 32'h5555_5555);
      #1;
      saw_req = saw_req | mem_req;
      checks++;
      if (LsuStall !== 1'b1) begin errors++; $display("FAIL illegal%0d_stall: got %b required 1", i, LsuStall); end
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      saw_req = saw_req | mem_req;
      checks++;
      if ({LsuDone, LsuFault, LsuStall, LoadData} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
        errors++;
        $display("FAIL illegal%0d_resp: done=%b fault=%b stall=%b data=%h required 1 1 0 00000000", i, LsuDone, LsuFault, LsuStall, LoadData);
      end
      next_cycle();
      saw_req = saw_req | mem_req;
      checks++;
      if ({saw_req, LsuDone} !== 2'b00) begin
        errors++; $display("FAIL illegal%0d_nobus: saw_req/done=%b required 00", i, {saw_req, LsuDone});
      end
      mem_gnt = 1'b0;
    end
  endtask

  task automatic test_gnt_delay();
    logic stable;
    stable = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0);
    mem_gnt = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0040) stable = 1'b0;
      if (c == 6) mem_gnt = 1'b1;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL gnt_delay_stable: got %b required 1", stable); end
    next_cycle();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    checks++;
    if ({mem_req, LsuDone, LsuStall} !== 3'b001) begin
      errors++; $display("FAIL gnt_delay_wait: req/done/stall=%b required 001", {mem_req, LsuDone, LsuStall});
    end
    next_cycle();
    mem_rvalid = 1'b0;
    checks++;
    if ({LsuDone, LsuFault, LoadData} !== {1'b1, 1'b0, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL gnt_delay_done: done=%b fault=%b data=%h required 1 0 cafef00d", LsuDone, LsuFault, LoadData);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int done_cyc;
    done_cyc = -1;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0080, 32'h0);
    mem_gnt = 1'b1;
    for (int c = 1; c < 40 && done_cyc < 0; c++) begin
      next_cycle();
      drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
      if (c == 2) mem_gnt = 1'b0;
      if (LsuDone === 1'b1) done_cyc = c;
    end
    checks++;
    if (done_cyc != 17) begin errors++; $display("FAIL timeout_cycle: done at cycle %0d required 17", done_cyc); end
    checks++;
    if ({LsuFault, LoadData} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL timeout_fault: fault=%b data=%h required 1 00000000", LsuFault, LoadData);
    end
    next_cycle();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    next_cycle();
    mem_rvalid = 1'b0;
    next_cycle();
    checks++;
    if ({LsuDone, LsuStall, LoadData} !== {1'b0, 1'b0, 32'h0}) begin
      errors++; $display("FAIL late_rvalid: done=%b stall=%b data=%h required 0 0 00000000", LsuDone, LsuStall, LoadData);
    end
  endtask

  task automatic test_reset_in_wait();
    logic stale;
    stale = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    mem_gnt = 1'b1;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    next_cycle();
    mem_gnt = 1'b0;
    checks++;
    if (LsuStall !== 1'b1) begin errors++; $display("FAIL rst_wait_pre: stall=%b required 1", LsuStall); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, LsuStall, LsuDone, LsuFault} !== 4'b0000) begin
      errors++; $display("FAIL rst_async: req/stall/done/fault=%b required 0000", {mem_req, LsuStall, LsuDone, LsuFault});
    end
    next_cycle(); next_cycle();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (LsuDone !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale !== 1'b0) begin errors++; $display("FAIL rst_stale_done: got %b required 0", stale); end
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0000_00A5);
    mem_gnt = 1'b1;
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_0010, 32'hA5A5_A5A5, 4'b0010}) begin
      errors++;
      $display("FAIL sb_after_rst: req=%b addr=%h wdata=%h wstrb=%b required 1 00000010 a5a5a5a5 0010",
               mem_req, mem_addr, mem_wdata, mem_wstrb);
    end
    next_cycle();
    mem_gnt = 1'b0;
    checks++;
    if ({LsuDone, LsuFault} !== 2'b10) begin errors++; $display("FAIL sb_after_rst_done: done/fault=%b required 10", {LsuDone, LsuFault}); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0BAD_F00D);
    mem_gnt = 1'b1;
    next_cycle();
    next_cycle();
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0104, 32'h0000_0077);
    #1;
    checks++;
    if ({LsuDone, LsuStall} !== 2'b10) begin
      errors++; $display("FAIL b2b_resp_no_accept: done/stall=%b required 10", {LsuDone, LsuStall});
    end
    next_cycle();
    checks++;
    if ({LsuStall, mem_req} !== 2'b10) begin
      errors++; $display("FAIL b2b_idle_start: stall/req=%b required 10", {LsuStall, mem_req});
    end
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    checks++;
    if ({mem_req, mem_addr, mem_wdata, mem_wstrb} !== {1'b1, 32'h0000_0104, 32'h7777_7777, 4'b0001}) begin
      errors++;
      $display("FAIL b2b_second_req: req=%b addr=%h wdata=%h wstrb=%b required 1 00000104 77777777 0001",
               mem_req, mem_addr, mem_wdata, mem_wstrb);
    end
    next_cycle();
    mem_gnt = 1'b0;
    checks++;
    if (LsuDone !== 1'b1) begin errors++; $display("FAIL b2b_second_done: got %b required 1", LsuDone); end
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_loads();
    test_store_half();
    test_illegal();
    test_gnt_delay();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
